dff_clear_n: RTL and testbench
==============================

Name: dff_clear_n

Overview:
- Edge-triggered D flip-flop with complementary outputs and an asynchronous active-low clear.
- Serves as the basic storage cell for the teaching-level sequential examples.
- Data width is parameterised, so the same block covers both single-bit and small register uses.
- Clear forces the stored state to a fixed value without waiting for a clock edge.

Parameters:
- WIDTH, 1, bit width of d, q and qb (legal range 1..64).
- CLEAR_VALUE, {WIDTH{1'b0}}, value q takes while clear is asserted.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low clear/reset.
- d  input  WIDTH  data input, sampled on the rising edge of clk.
- q  output  WIDTH  registered data.
- qb  output  WIDTH  bitwise complement of q.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low, on port clear.
- Clear asserted (clear=0):
  - q = CLEAR_VALUE and qb = ~CLEAR_VALUE immediately, in the same simulation time step and without any clock edge.
  - Clear takes priority over any clock edge while it is low.
  - d is ignored for as long as clear is low.
- Clear released (clear 0->1):
  - No output change at the release itself; q holds CLEAR_VALUE.
  - The first rising edge of clk after release captures d.
- Normal operation (clear=1): on each rising edge of clk, q <= d. Latency is one clock edge, with no combinational path from d to q.
- Between rising edges, q holds its value. Changes on d are ignored; a falling edge has no effect.
- qb is derived from the stored state, never registered separately. Required invariant: qb == ~q at all times, including during clear.
- Simultaneous events:
  - Clear falling at the same instant as a rising edge of clk: clear wins, so q = CLEAR_VALUE.
  - Clear rising at the same instant as a rising edge of clk: that edge captures d.
- Power-up without clear: q is undefined (X in simulation) until the first rising edge or a clear. No implicit initial value is allowed in RTL.
- Width rule: all bits are processed independently and identically; there is no arithmetic.

Optional Feature:
- Macro: DFF_CLEAR_N_ENABLE_EN.
- Defined:
  - Adds input port en (1 bit), placed after d.
  - On a rising edge with clear=1: q <= d when en=1; q holds when en=0.
  - Clear still overrides en asynchronously.
  - qb == ~q still holds at all times.
- Undefined:
  - Port en does not exist.
  - The flop loads d on every rising edge.

Test Plan:
1. Setup for all scenarios: WIDTH=1, clk period 10 (rising edges at t=5,15,25,...), clear=1, d=0 at t=0. Edge t=5 -> q=0, qb=1.
2. d toggles 1,0,1,0,1 at t=10,20,30,40,50 -> q follows on edges t=15..55 (q=1,0,1,0,1) with qb complementary. q never changes at the d transitions themselves.
3. Async clear: with q=1, drive clear=0 at t=60 (mid-cycle) -> q=0, qb=1 at t=60. Edge t=65 with d=1 -> q stays 0.
4. Release: clear=1 at t=70 -> q stays 0 at t=70. Edge t=75 with d=1 -> q=1, qb=0. Free-run to t=170 with d=1 -> q stays 1.
5. Wide/simultaneous: WIDTH=8, CLEAR_VALUE=8'hA5, d=8'h3C.
   - Clear falls exactly on a rising edge -> q=8'hA5, qb=8'h5A.
   - Release, then next edge -> q=8'h3C, qb=8'hC3.
6. With DFF_CLEAR_N_ENABLE_EN defined:
   - en=0 and d toggling over 3 edges -> q holds its prior value.
   - en=1 -> q follows d on the next edge.
   - clear=0 with en=0 -> q=CLEAR_VALUE immediately.

Source files
------------

// File: rtl/dff_clear_n.sv
// dff_clear_n: D flip-flop with complementary outputs and asynchronous active-low clear.
// Define DFF_CLEAR_N_ENABLE_EN to add a synchronous load enable (port en, after d).
module dff_clear_n #(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   CLEAR_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
`ifdef DFF_CLEAR_N_ENABLE_EN
    input  logic             en,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

`ifdef DFF_CLEAR_N_ENABLE_EN
    // Clear wins asynchronously; otherwise load d on rising edges where en is high.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            q <= CLEAR_VALUE;
        else if (en)
            q <= d;
    end
`else
    // Clear wins asynchronously; otherwise load d on every rising edge.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear)
            q <= CLEAR_VALUE;
        else
            q <= d;
    end
`endif

    // Derived from the stored state so qb can never disagree with q, even during clear.
    assign qb = ~q;

endmodule

// File: tb/tb_dff_clear_n.sv
// tb_dff_clear_n: directed scoreboard bench for dff_clear_n (1-bit and 8-bit instances).
module tb_dff_clear_n;

    logic       clk = 1'b0;
    logic       clear1;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic       clear8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;
`ifdef DFF_CLEAR_N_ENABLE_EN
    logic       en1;
    logic       en8;
`endif

    logic [7:0] sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       v;

    always #5 clk = ~clk;

    dff_clear_n #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .clear (clear1),
        .d     (d1),
`ifdef DFF_CLEAR_N_ENABLE_EN
        .en    (en1),
`endif
        .q     (q1),
        .qb    (qb1)
    );

    dff_clear_n #(.WIDTH(8), .CLEAR_VALUE(8'hA5)) dut8 (
        .clk   (clk),
        .clear (clear8),
        .d     (d8),
`ifdef DFF_CLEAR_N_ENABLE_EN
        .en    (en8),
`endif
        .q     (q8),
        .qb    (qb8)
    );

    task automatic push(input logic [7:0] e);
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<nothing queued>", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    initial begin
        clear1 = 1'b1;
        d1     = 1'b0;
        clear8 = 1'b1;
        d8     = 8'h3C;
`ifdef DFF_CLEAR_N_ENABLE_EN
        en1 = 1'b1;
        en8 = 1'b1;
`endif
        // first edge at t=5 loads d=0
        #6;
        push(8'h00); check("init_q", {7'b0, q1});
        push(8'h01); check("init_qb", {7'b0, qb1});
        // d toggles mid-cycle; q must only move on the following edge
        for (int i = 0; i < 5; i++) begin
            v = (i % 2 == 0);
            #4 d1 = v;
            #1 push({7'b0, ~v}); check("hold_at_d_change", {7'b0, q1});
            #5 push({7'b0, v});  check("follow_q", {7'b0, q1});
            push({7'b0, ~v});    check("follow_qb", {7'b0, qb1});
        end
        // async clear mid-cycle at t=60
        #4 clear1 = 1'b0;
        #1 push(8'h00); check("clr_async_q", {7'b0, q1});
        push(8'h01); check("clr_async_qb", {7'b0, qb1});
        d1 = 1'b1;
        #5 push(8'h00); check("clr_blocks_edge", {7'b0, q1});
        // release at t=70, capture at t=75
        #4 clear1 = 1'b1;
        #1 push(8'h00); check("release_hold", {7'b0, q1});
        #5 push(8'h01); check("release_cap_q", {7'b0, q1});
        push(8'h00); check("release_cap_qb", {7'b0, qb1});
        repeat (10) begin
            @(posedge clk);
            #1 push(8'h01); check("free_run_q", {7'b0, q1});
        end
        // wide instance: clear falls exactly on a rising edge (q was 3C)
        @(posedge clk) clear8 = 1'b0;
        #1 push(8'hA5); check("w_clr_on_edge_q", q8);
        push(8'h5A); check("w_clr_on_edge_qb", qb8);
        d8 = 8'hFF;
        repeat (2) @(posedge clk);
        #1 push(8'hA5); check("w_ignore_d", q8);
        d8 = 8'h3C;
        #3 clear8 = 1'b1;
        #1 push(8'hA5); check("w_release_hold", q8);
        @(posedge clk);
        #1 push(8'h3C); check("w_cap_q", q8);
        push(8'hC3); check("w_cap_qb", qb8);
        d8 = 8'h96;
        @(posedge clk);
        #1 push(8'h96); check("w_bits_q", q8);
        push(8'h69); check("w_bits_qb", qb8);
`ifdef DFF_CLEAR_N_ENABLE_EN
        en8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d8 = (i % 2 == 0) ? 8'h0F : 8'hF0;
            @(posedge clk);
            #1 push(8'h96); check("en_hold_q", q8);
        end
        en8 = 1'b1;
        d8  = 8'h5C;
        @(posedge clk);
        #1 push(8'h5C); check("en_load_q", q8);
        push(8'hA3); check("en_load_qb", qb8);
        en8 = 1'b0;
        #2 clear8 = 1'b0;
        #1 push(8'hA5); check("en_clr_q", q8);
        push(8'h5A); check("en_clr_qb", qb8);
`endif
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
